// File: rtl/bitcoin_miner.sv
// Nonce-sweeping double SHA-256 miner: midstate of header words 0..15 once, then
// SHA256(SHA256(header||nonce)) per nonce, H0 compared against a target.
module bitcoin_miner #(
  parameter int unsigned NUM_NONCES = 16,
  parameter bit          WRITE_ALL  = 1'b1,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic [31:0] nonce_start,
  input  logic [31:0] target,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [3:0] {IDLE, FETCH, MID, TAIL, BLK2, BLK3, CMP, WRITE, FIN} state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_NONCES - 1);
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [15:0][31:0] blk2_words(input logic [31:0] w16, w17, w18, n);
    return {32'd640, {10{32'h0}}, 32'h8000_0000, n, w18, w17, w16};
  endfunction
  function automatic logic [15:0][31:0] blk3_words(input logic [7:0][31:0] h);
    return {32'd256, {6{32'h0}}, 32'h8000_0000, h};
  endfunction

  state_t            state_q, state_d;
  logic [15:0]       msg_addr_q, msg_addr_d, out_addr_q, out_addr_d, idx_q, idx_d;
  logic [31:0]       nonce_q, nonce_d, target_q, target_d, h0_q, h0_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [15:0][31:0] w_q, w_d;
  logic [7:0][31:0]  st_q, st_d, mid_q, mid_d;
  logic [2:0][31:0]  tail_q, tail_d;
  logic              match_q, match_d, found_q, found_d, busy_q, busy_d, done_q, done_d;
  logic [31:0]       found_nonce_q, found_nonce_d, mem_wd_q, mem_wd_d;
  logic              mem_we_q, mem_we_d;
  logic [15:0]       mem_addr_q, mem_addr_d;

  logic [31:0]       ch, maj, t1, t2, w_new;
  logic [7:0][31:0]  st_n, h2, mid_new;
  logic [15:0][31:0] w_shift;
  logic              match_now, stop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      msg_addr_q    <= '0;
      out_addr_q    <= '0;
      idx_q         <= '0;
      nonce_q       <= '0;
      target_q      <= '0;
      h0_q          <= '0;
      cnt_q         <= '0;
      w_q           <= '0;
      st_q          <= '0;
      mid_q         <= '0;
      tail_q        <= '0;
      match_q       <= 1'b0;
      found_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_nonce_q <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wd_q      <= '0;
    end else begin
      state_q       <= state_d;
      msg_addr_q    <= msg_addr_d;
      out_addr_q    <= out_addr_d;
      idx_q         <= idx_d;
      nonce_q       <= nonce_d;
      target_q      <= target_d;
      h0_q          <= h0_d;
      cnt_q         <= cnt_d;
      w_q           <= w_d;
      st_q          <= st_d;
      mid_q         <= mid_d;
      tail_q        <= tail_d;
      match_q       <= match_d;
      found_q       <= found_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      found_nonce_q <= found_nonce_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wd_q      <= mem_wd_d;
    end
  end

  // One SHA-256 round plus the sliding-window schedule step; w_q[0] is W[t].
  always_comb begin
    ch      = (st_q[4] & st_q[5]) ^ (~st_q[4] & st_q[6]);
    maj     = (st_q[0] & st_q[1]) ^ (st_q[0] & st_q[2]) ^ (st_q[1] & st_q[2]);
    t1      = st_q[7] + bsig1(st_q[4]) + ch + K[cnt_q] + w_q[0];
    t2      = bsig0(st_q[0]) + maj;
    st_n    = {st_q[6:4], st_q[3] + t1, st_q[2:0], t1 + t2};
    w_new   = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    w_shift = {w_new, w_q[15:1]};
    for (int unsigned j = 0; j < 8; j++) begin
      h2[j]      = mid_q[j] + st_n[j];
      mid_new[j] = IV[j] + st_n[j];
    end
    match_now = h0_q < target_q;
    stop      = (EARLY_EXIT && ((state_q == CMP) ? match_now : match_q)) || (idx_q == LAST_IDX);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (cnt_q == 6'd16) state_d = MID;
      MID:     if (cnt_q == 6'd63) state_d = TAIL;
      TAIL:    if (cnt_q == 6'd3) state_d = BLK2;
      BLK2:    if (cnt_q == 6'd63) state_d = BLK3;
      BLK3:    if (cnt_q == 6'd63) state_d = CMP;
      CMP:     state_d = WRITE_ALL ? WRITE : (stop ? FIN : BLK2);
      WRITE:   state_d = stop ? FIN : BLK2;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    msg_addr_d    = msg_addr_q;
    out_addr_d    = out_addr_q;
    idx_d         = idx_q;
    nonce_d       = nonce_q;
    target_d      = target_q;
    h0_d          = h0_q;
    cnt_d         = cnt_q + 6'd1;
    w_d           = w_q;
    st_d          = st_q;
    mid_d         = mid_q;
    tail_d        = tail_q;
    match_d       = match_q;
    found_d       = found_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    found_nonce_d = found_nonce_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wd_d      = mem_wd_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          msg_addr_d    = message_addr;
          out_addr_d    = output_addr;
          nonce_d       = nonce_start;
          target_d      = target;
          mem_addr_d    = message_addr;
          idx_d         = '0;
          busy_d        = 1'b1;
          found_d       = 1'b0;
          found_nonce_d = '0;
        end
      end
      FETCH: begin
        if (cnt_q != 6'd0) w_d = {mem_read_data, w_q[15:1]};
        if (cnt_q != 6'd16) begin
          mem_addr_d = msg_addr_q + 16'(cnt_q) + 16'd1;
        end else begin
          st_d  = IV;
          cnt_d = '0;
        end
      end
      MID: begin
        st_d = st_n;
        w_d  = w_shift;
        if (cnt_q == 6'd63) mid_d = mid_new;
      end
      // mem_addr still holds message_addr+16 from FETCH on entry.
      TAIL: begin
        unique case (cnt_q)
          6'd0: mem_addr_d = msg_addr_q + 16'd17;
          6'd1: begin
            tail_d[0]  = mem_read_data;
            mem_addr_d = msg_addr_q + 16'd18;
          end
          6'd2: tail_d[1] = mem_read_data;
          default: begin
            tail_d[2] = mem_read_data;
            w_d       = blk2_words(tail_q[0], tail_q[1], mem_read_data, nonce_q);
            st_d      = mid_q;
            cnt_d     = '0;
          end
        endcase
      end
      BLK2: begin
        st_d = st_n;
        w_d  = w_shift;
        if (cnt_q == 6'd63) begin
          w_d  = blk3_words(h2);
          st_d = IV;
        end
      end
      BLK3: begin
        st_d = st_n;
        w_d  = w_shift;
        if (cnt_q == 6'd63) h0_d = IV[0] + st_n[0];
      end
      CMP, WRITE: begin
        if (state_q == CMP) begin
          match_d = match_now;
          if (match_now && !found_q) begin
            found_d       = 1'b1;
            found_nonce_d = nonce_q;
          end
        end
        if (state_q == CMP && WRITE_ALL) begin
          mem_we_d   = 1'b1;
          mem_addr_d = out_addr_q + idx_q;
          mem_wd_d   = h0_q;
        end else if (stop) begin
          done_d = 1'b1;
        end else begin
          idx_d   = idx_q + 16'd1;
          nonce_d = nonce_q + 32'd1;
          w_d     = blk2_words(tail_q[0], tail_q[1], tail_q[2], nonce_q + 32'd1);
          st_d    = mid_q;
          cnt_d   = '0;
        end
      end
      FIN:     busy_d = 1'b0;
      default: ;
    endcase
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign found          = found_q;
  assign found_nonce    = found_nonce_q;
  assign mem_clk        = clk;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wd_q;

endmodule

// File: tb/tb_bitcoin_miner.sv
// Scoreboard bench for bitcoin_miner: four parameterisations share one header memory;
// expected writes and done records come from a behavioural SHA-256 model.
module tb_bitcoin_miner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] message_addr, output_addr;
  logic [31:0] nonce_start, target;
  logic        start [4];
  logic        busy [4], done [4], found [4], mem_clk [4], mem_we [4];
  logic [31:0] found_nonce [4], mem_wd [4], rd [4];
  logic [15:0] mem_addr [4];

  bitcoin_miner u0 (.clk(clk), .reset(reset), .start(start[0]), .message_addr(message_addr),
    .output_addr(output_addr), .nonce_start(nonce_start), .target(target), .busy(busy[0]),
    .done(done[0]), .found(found[0]), .found_nonce(found_nonce[0]), .mem_clk(mem_clk[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_write_data(mem_wd[0]), .mem_read_data(rd[0]));
  bitcoin_miner #(.NUM_NONCES(16), .WRITE_ALL(1'b1), .EARLY_EXIT(1'b1)) u1 (.clk(clk), .reset(reset),
    .start(start[1]), .message_addr(message_addr), .output_addr(output_addr), .nonce_start(nonce_start),
    .target(target), .busy(busy[1]), .done(done[1]), .found(found[1]), .found_nonce(found_nonce[1]),
    .mem_clk(mem_clk[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_write_data(mem_wd[1]),
    .mem_read_data(rd[1]));
  bitcoin_miner #(.NUM_NONCES(4)) u2 (.clk(clk), .reset(reset), .start(start[2]),
    .message_addr(message_addr), .output_addr(output_addr), .nonce_start(nonce_start), .target(target),
    .busy(busy[2]), .done(done[2]), .found(found[2]), .found_nonce(found_nonce[2]), .mem_clk(mem_clk[2]),
    .mem_we(mem_we[2]), .mem_addr(mem_addr[2]), .mem_write_data(mem_wd[2]), .mem_read_data(rd[2]));
  bitcoin_miner #(.NUM_NONCES(1), .WRITE_ALL(1'b0)) u3 (.clk(clk), .reset(reset), .start(start[3]),
    .message_addr(message_addr), .output_addr(output_addr), .nonce_start(nonce_start), .target(target),
    .busy(busy[3]), .done(done[3]), .found(found[3]), .found_nonce(found_nonce[3]), .mem_clk(mem_clk[3]),
    .mem_we(mem_we[3]), .mem_addr(mem_addr[3]), .mem_write_data(mem_wd[3]), .mem_read_data(rd[3]));

  logic [31:0] mem [65536];
  always @(posedge clk) for (int k = 0; k < 4; k++) rd[k] <= mem[mem_addr[k]];

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
            e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
  endfunction

  logic [31:0] hdr [19];

  function automatic logic [31:0] model_h0(input logic [31:0] n);
    logic [511:0] b1;
    logic [255:0] mid, h2, hf;
    for (int j = 0; j < 16; j++) b1[511 - 32*j -: 32] = hdr[j];
    mid = compress(IV, b1);
    h2  = compress(mid, {hdr[16], hdr[17], hdr[18], n, 32'h8000_0000, 320'h0, 32'd640});
    hf  = compress(IV, {h2, 32'h8000_0000, 192'h0, 32'd256});
    return hf[255:224];
  endfunction

  typedef struct packed { logic [1:0] inst; logic [15:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [1:0] inst; logic fnd; logic [31:0] fn; } dn_t;
  wr_t wq [$];
  dn_t dq [$];
  wr_t we_e;
  dn_t dn_e;
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_we[k]) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: inst %0d addr %0h data %0h, expected no write", k, mem_addr[k], mem_wd[k]);
        end else begin
          we_e = wq.pop_front();
          check("write_inst", 64'(k), 64'(we_e.inst));
          check("write_addr", 64'(mem_addr[k]), 64'(we_e.addr));
          check("write_data", 64'(mem_wd[k]), 64'(we_e.data));
        end
      end
      if (done[k]) begin
        check("busy_with_done", 64'(busy[k]), 64'd1);
        if (dq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: inst %0d, expected no done", k);
        end else begin
          dn_e = dq.pop_front();
          check("done_inst", 64'(k), 64'(dn_e.inst));
          check("found", 64'(found[k]), 64'(dn_e.fnd));
          check("found_nonce", 64'(found_nonce[k]), 64'(dn_e.fn));
        end
      end
    end
  end

  task automatic load_header(input logic [31:0] seed);
    for (int j = 0; j < 19; j++) hdr[j] = seed * 32'h9E37_79B9 + 32'(j) * 32'h0101_0101 + 32'h1357_9BDF;
  endtask

  task automatic store_header();
    for (int j = 0; j < 19; j++) mem[message_addr + 16'(j)] = hdr[j];
  endtask

  task automatic predict(input int k, input logic [15:0] oaddr, input logic [31:0] ns, input logic [31:0] tgt,
                         input int nn, input bit wa, input bit ee, input int upto, input bit pdone,
                         output int nproc);
    logic [31:0] n, h, fn;
    logic fnd;
    fnd = 1'b0; fn = '0; nproc = 0;
    for (int i = 0; i < nn && i < upto; i++) begin
      n = ns + 32'(i);
      h = model_h0(n);
      nproc++;
      if (wa) wq.push_back('{inst: 2'(k), addr: oaddr + 16'(i), data: h});
      if (h < tgt && !fnd) begin fnd = 1'b1; fn = n; end
      if (ee && h < tgt) break;
    end
    if (pdone) dq.push_back('{inst: 2'(k), fnd: fnd, fn: fn});
  endtask

  task automatic check_zero(input int k);
    check("zero_busy", 64'(busy[k]), 64'd0);
    check("zero_done", 64'(done[k]), 64'd0);
    check("zero_found", 64'(found[k]), 64'd0);
    check("zero_found_nonce", 64'(found_nonce[k]), 64'd0);
    check("zero_mem_we", 64'(mem_we[k]), 64'd0);
    check("zero_mem_addr", 64'(mem_addr[k]), 64'd0);
    check("zero_mem_wdata", 64'(mem_wd[k]), 64'd0);
  endtask

  task automatic start_pulse(input int k);
    @(posedge clk); #1 start[k] = 1'b1;
    @(posedge clk); #1 start[k] = 1'b0;
    check("busy_after_start", 64'(busy[k]), 64'd1);
    check("addr_after_start", 64'(mem_addr[k]), 64'(message_addr));
  endtask

  task automatic do_run(input int k, input logic [15:0] oaddr, input logic [31:0] ns,
                        input logic [31:0] tgt, input int nproc);
    int cyc;
    output_addr = oaddr; nonce_start = ns; target = tgt;
    start_pulse(k);
    cyc = 0;
    while (!done[k] && cyc < 24 + 66 + nproc * 135) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_within_bound", 64'(done[k]), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("busy_low_after_done", 64'(busy[k]), 64'd0);
    check("writes_pending", 64'(wq.size()), 64'd0);
    check("done_pending", 64'(dq.size()), 64'd0);
    wq.delete(); dq.delete();
  endtask

  logic [255:0] abc_h;
  logic [31:0]  hv [6];
  bit           ok;
  int           np;

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 4; k++) start[k] = 1'b0;
    message_addr = 16'h0100; output_addr = '0; nonce_start = '0; target = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check_zero(k);
    reset = 1'b0;

    abc_h = compress(IV, {32'h6162_6380, 448'h0, 32'h18});
    check("model_sha256_abc", 64'(abc_h[255:224]), 64'hba78_16bf);

    // Full sweep, everything matches, output window wraps past 0xFFFF.
    load_header(32'd1); store_header();
    predict(0, 16'hFFF8, 32'h0, 32'hFFFF_FFFF, 16, 1'b1, 1'b0, 16, 1'b1, np);
    do_run(0, 16'hFFF8, 32'h0, 32'hFFFF_FFFF, np);

    // Target 0: nothing can match.
    predict(0, 16'h0200, 32'h0, 32'h0, 16, 1'b1, 1'b0, 16, 1'b1, np);
    do_run(0, 16'h0200, 32'h0, 32'h0, np);

    // Early exit: pick a header whose nonce-5 H0 is below nonces 0..4.
    load_header(32'd7);
    for (int v = 0; v < 500; v++) begin
      hdr[3] = 32'(v);
      for (int i = 0; i < 6; i++) hv[i] = model_h0(32'(i));
      ok = 1'b1;
      for (int i = 0; i < 5; i++) if (hv[i] <= hv[5]) ok = 1'b0;
      if (ok) break;
    end
    store_header();
    predict(1, 16'h0400, 32'h0, hv[5] + 32'd1, 16, 1'b1, 1'b1, 16, 1'b1, np);
    check("early_exit_model_count", 64'(np), 64'd6);
    do_run(1, 16'h0400, 32'h0, hv[5] + 32'd1, np);

    // Nonce wrap across 2^32.
    load_header(32'd3); store_header();
    predict(2, 16'h0600, 32'hFFFF_FFFE, 32'h8000_0000, 4, 1'b1, 1'b0, 4, 1'b1, np);
    do_run(2, 16'h0600, 32'hFFFF_FFFE, 32'h8000_0000, np);

    // Extra start mid-run is ignored; reset during nonce 3 aborts silently.
    load_header(32'd11); store_header();
    output_addr = 16'h0300; nonce_start = 32'h100; target = 32'h4000_0000;
    predict(0, 16'h0300, 32'h100, 32'h4000_0000, 16, 1'b1, 1'b0, 3, 1'b0, np);
    start_pulse(0);
    repeat (40) @(posedge clk);
    #1 start[0] = 1'b1; message_addr = 16'h0500; nonce_start = 32'h0;
    @(posedge clk); #1 start[0] = 1'b0; message_addr = 16'h0100; nonce_start = 32'h100;
    check("busy_after_extra_start", 64'(busy[0]), 64'd1);
    repeat (455) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check_zero(0);
    reset = 1'b0;
    check("writes_before_reset", 64'(wq.size()), 64'd0);
    repeat (400) @(posedge clk);
    #1;
    check("idle_after_reset", 64'(busy[0]), 64'd0);
    predict(0, 16'h0300, 32'h100, 32'h4000_0000, 16, 1'b1, 1'b0, 16, 1'b1, np);
    do_run(0, 16'h0300, 32'h100, 32'h4000_0000, np);

    // Single nonce, no writes, match reported only via found.
    load_header(32'd5); store_header();
    predict(3, 16'h0700, 32'h1234_5678, 32'h8000_0000, 1, 1'b0, 1'b0, 1, 1'b1, np);
    do_run(3, 16'h0700, 32'h1234_5678, 32'h8000_0000, np);
    predict(3, 16'h0700, 32'h1234_5678, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 1, 1'b1, np);
    do_run(3, 16'h0700, 32'h1234_5678, 32'hFFFF_FFFF, np);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
